// File: rtl/anton_neopixel_apb_multi.sv
// APB-slave WS2812 controller: pixel buffer, CTRL/STATUS registers and bit serialiser on one clock.
// Optional NEOPIXEL_APB_READBACK_EN: buffer addresses read back the stored byte instead of 0.
module anton_neopixel_apb_multi #(
  parameter int PIXELS = 8,
  parameter int ADDR_W = 8,
  parameter int T0H    = 4,
  parameter int T1H    = 8,
  parameter int TBIT   = 13,
  parameter int TRESET = 500
) (
  input  logic              apbPclk,
  input  logic              apbPreset,
  input  logic              apbPsel,
  input  logic              apbPenable,
  input  logic              apbPwrite,
  input  logic [ADDR_W-1:0] apbPaddr,
  input  logic [7:0]        apbPwData,
  output logic [7:0]        apbPrData,
  output logic              apbPready,
  output logic              apbPslverr,
  output logic              neoData,
  output logic              neoState
);

  localparam int NBYTES = 3 * PIXELS;
  localparam int IW     = $clog2(NBYTES);
  localparam int CMAX   = (TBIT > TRESET) ? TBIT : TRESET;
  localparam int CW     = (CMAX > 2) ? $clog2(CMAX) : 1;

  localparam logic [ADDR_W-1:0] A_CTRL = '1;
  localparam logic [ADDR_W-1:0] A_STAT = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] A_NBUF = ADDR_W'(NBYTES);
  localparam logic [CW-1:0]     C_BIT_END = CW'(TBIT - 1);
  localparam logic [CW-1:0]     C_GAP_END = CW'(TRESET - 1);
  localparam logic [CW-1:0]     C_T0_END  = CW'(T0H - 1);
  localparam logic [CW-1:0]     C_T1_END  = CW'(T1H - 1);
  localparam logic [IW-1:0]     I_LAST    = IW'(NBYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_GAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_loop;
  logic            r_done;
  logic [7:0]      r_mem [NBYTES];

  logic            w_access, w_wr, w_busy, w_is_buf, w_is_ctrl, w_is_stat, w_unmapped;
  logic            w_start, w_buf_wr, w_gap_end, w_bit_end, w_last;
  logic [CW-1:0]   w_hi_end;
  logic [IW-1:0]   w_idx_nxt;
  logic [IW-1:0]   w_baddr;

  assign w_access   = apbPsel & apbPenable;
  assign w_wr       = w_access & apbPwrite;
  assign w_busy     = (r_state != S_IDLE);
  assign w_is_buf   = (apbPaddr < A_NBUF);
  assign w_is_ctrl  = (apbPaddr == A_CTRL);
  assign w_is_stat  = (apbPaddr == A_STAT);
  assign w_unmapped = ~w_is_buf & ~w_is_ctrl & ~w_is_stat;
  assign w_baddr    = apbPaddr[IW-1:0];

  assign w_start    = w_wr & w_is_ctrl & apbPwData[0] & ~w_busy;
  assign w_buf_wr   = w_wr & w_is_buf & ~w_busy;
  assign w_gap_end  = (r_state == S_GAP) && (r_cnt == C_GAP_END);
  assign w_bit_end  = (r_cnt == C_BIT_END);
  assign w_last     = (r_idx == I_LAST);
  assign w_hi_end   = r_shift[7] ? C_T1_END : C_T0_END;
  assign w_idx_nxt  = r_idx + IW'(1);

  assign apbPready  = 1'b1;
  assign apbPslverr = w_access & (w_unmapped | (apbPwrite & w_is_buf & w_busy));

  // FSM state register
  always_ff @(posedge apbPclk or posedge apbPreset) begin
    if (apbPreset) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // FSM next state; LOAD only appears on a fresh START, later byte fetches overlap the last LOW cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_HIGH;
      S_HIGH: if (r_cnt == w_hi_end) w_state_nxt = S_LOW;
      S_LOW:  if (w_bit_end) w_state_nxt = ((r_bit == 3'd0) && w_last) ? S_GAP : S_HIGH;
      S_GAP:  if (w_gap_end) w_state_nxt = r_loop ? S_HIGH : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    neoData  = (r_state == S_HIGH);
    neoState = w_busy;
  end

  // Serialiser datapath: one counter covers both the bit period and the latch gap
  always_ff @(posedge apbPclk or posedge apbPreset) begin
    if (apbPreset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
        end
        S_LOAD: begin
          r_shift <= r_mem[r_idx];
          r_bit   <= 3'd7;
          r_cnt   <= '0;
        end
        S_HIGH: r_cnt <= r_cnt + CW'(1);
        S_LOW: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit != 3'd0) begin
              r_bit   <= r_bit - 3'd1;
              r_shift <= {r_shift[6:0], 1'b0};
            end else if (!w_last) begin
              r_idx   <= w_idx_nxt;
              r_shift <= r_mem[w_idx_nxt];
              r_bit   <= 3'd7;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (w_gap_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= r_mem[0];
            r_bit   <= 3'd7;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // DONE: gap-end set wins over a same-cycle W1 clear
  always_ff @(posedge apbPclk or posedge apbPreset) begin
    if (apbPreset) begin
      r_loop <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_wr && w_is_ctrl) r_loop <= apbPwData[1];
      if (w_gap_end)                               r_done <= 1'b1;
      else if (w_wr && w_is_stat && apbPwData[1]) r_done <= 1'b0;
    end
  end

  // Pixel buffer keeps its contents across reset
  always_ff @(posedge apbPclk) begin
    if (w_buf_wr) r_mem[w_baddr] <= apbPwData;
  end

  always_comb begin
    apbPrData = 8'h00;
    if (w_is_ctrl)      apbPrData = {6'b0, r_loop, 1'b0};
    else if (w_is_stat) apbPrData = {6'b0, r_done, w_busy};
    else if (w_is_buf) begin
`ifdef NEOPIXEL_APB_READBACK_EN
      apbPrData = r_mem[w_baddr];
`else
      apbPrData = 8'h00;
`endif
    end
  end

endmodule

// File: tb/tb_anton_neopixel_apb_multi.sv
// Self-checking bench: randomized pixel frames compared against a waveform model built from the bit rules.
module tb_anton_neopixel_apb_multi;

  localparam int PIX = 2, AW = 8, T0H = 4, T1H = 8, TBIT = 13, TRESET = 500;
  localparam int NB = 3 * PIX;
  localparam int FRAME = NB * 8 * TBIT;
  localparam int L = FRAME + TRESET;
  localparam logic [7:0] A_CTRL = 8'hFF, A_STAT = 8'hFE;

  logic clk = 1'b0, rst = 1'b1;
  logic psel = 0, penable = 0, pwrite = 0;
  logic [AW-1:0] paddr = '0;
  logic [7:0] pwdata = '0, prdata;
  logic pready, pslverr, neo_d, neo_s;

  int checks = 0, errors = 0;

  logic [7:0] buf_m [NB];
  logic       exp_d [L];
  logic       obs_d [4096];
  logic       obs_s [4096];

  always #5 clk = ~clk;

  anton_neopixel_apb_multi #(.PIXELS(PIX), .ADDR_W(AW), .T0H(T0H), .T1H(T1H), .TBIT(TBIT),
                             .TRESET(TRESET)) dut (
    .apbPclk(clk), .apbPreset(rst), .apbPsel(psel), .apbPenable(penable), .apbPwrite(pwrite),
    .apbPaddr(paddr), .apbPwData(pwdata), .apbPrData(prdata), .apbPready(pready),
    .apbPslverr(pslverr), .neoData(neo_d), .neoState(neo_s));

  // Reference waveform: each bit is a high pulse of T0H/T1H then low to TBIT, then the latch gap
  task automatic build_exp();
    int k = 0;
    for (int b = 0; b < NB; b++)
      for (int i = 7; i >= 0; i--) begin
        int h = buf_m[b][i] ? T1H : T0H;
        for (int c = 0; c < TBIT; c++) begin exp_d[k] = (c < h); k++; end
      end
    for (int g = 0; g < TRESET; g++) begin exp_d[k] = 1'b0; k++; end
  endtask

  function automatic logic [7:0] exp_rb(input int a);
`ifdef NEOPIXEL_APB_READBACK_EN
    return buf_m[a];
`else
    return 8'h00;
`endif
  endfunction

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d, output logic err);
    @(posedge clk); #1 psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1; #1 err = pslverr;
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic err);
    @(posedge clk); #1 psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1 penable = 1; #1 d = prdata; err = pslverr;
    @(posedge clk); #1 psel = 0; penable = 0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 obs_d[i] = neo_d; obs_s[i] = neo_s;
    end
  endtask

  task automatic fill_buffer();
    logic e;
    int nerr = 0;
    for (int a = 0; a < NB; a++) begin
      apb_write(8'(a), buf_m[a], e);
      if (e) nerr++;
    end
    checks++;
    if (nerr !== 0) begin errors++; $display("FAIL fill_err: got %0d errored writes, want 0", nerr); end
  endtask

  task automatic test_reset();
    logic [7:0] d; logic e;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({neo_d, neo_s} !== 2'b00) begin
      errors++; $display("FAIL reset_out: got %b, want 00", {neo_d, neo_s});
    end
    @(negedge clk) rst = 0;
    apb_read(A_CTRL, d, e);
    checks++;
    if ({e, d} !== 9'h000) begin errors++; $display("FAIL reset_ctrl: got %h err %b, want 00", d, e); end
    apb_read(A_STAT, d, e);
    checks++;
    if ({e, d} !== 9'h000) begin errors++; $display("FAIL reset_stat: got %h err %b, want 00", d, e); end
    checks++;
    if (pready !== 1'b1) begin errors++; $display("FAIL pready: got %b, want 1", pready); end
  endtask

  task automatic test_readback();
    logic [7:0] d; logic e;
    for (int a = 0; a < NB; a++) buf_m[a] = 8'(a * 17);
    fill_buffer();
    apb_write(8'd2, 8'hA5, e);
    buf_m[2] = 8'hA5;
    apb_read(8'd2, d, e);
    checks++;
    if ({e, d} !== {1'b0, exp_rb(2)}) begin
      errors++; $display("FAIL readback_a5: got %h err %b, want %h", d, e, exp_rb(2));
    end
    apb_read(8'd5, d, e);
    checks++;
    if ({e, d} !== {1'b0, exp_rb(5)}) begin
      errors++; $display("FAIL readback_5: got %h err %b, want %h", d, e, exp_rb(5));
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] d; logic e;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a = (i == 0) ? 8'(NB) : 8'($urandom_range(NB, 253));
      apb_read(a, d, e);
      checks++;
      if ({e, d} !== 9'h100) begin errors++; $display("FAIL unmap_rd %h: got %h err %b, want 00 err 1", a, d, e); end
      apb_write(a, 8'($urandom), e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL unmap_wr %h: got err %b, want 1", a, e); end
    end
    apb_read(A_STAT, d, e);
    checks++;
    if ({e, d} !== 9'h000) begin errors++; $display("FAIL unmap_stat: got %h, want 00", d); end
    checks++;
    if (neo_s !== 1'b0) begin errors++; $display("FAIL unmap_busy: got %b, want 0", neo_s); end
    apb_read(8'd2, d, e);
    checks++;
    if (d !== exp_rb(2)) begin errors++; $display("FAIL unmap_buf: got %h, want %h", d, exp_rb(2)); end
  endtask

  task automatic run_and_check_frame(input string tag);
    logic [7:0] d; logic e;
    int bad_d = 0, bad_s = 0, first = -1;
    build_exp();
    apb_write(A_CTRL, 8'h01, e);
    capture(L + 1);
    for (int i = 0; i <= L; i++) begin
      logic ed = (i < L) ? exp_d[i] : 1'b0;
      logic es = (i < L);
      if (obs_d[i] !== ed) begin bad_d++; if (first < 0) first = i; end
      if (obs_s[i] !== es) bad_s++;
    end
    checks++;
    if (bad_d !== 0) begin errors++; $display("FAIL %s wave: got %0d bad cycles (first %0d), want 0", tag, bad_d, first); end
    checks++;
    if (bad_s !== 0) begin errors++; $display("FAIL %s busy: got %0d bad cycles, want 0", tag, bad_s); end
    apb_read(A_STAT, d, e);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL %s done: got %h, want 02", tag, d); end
    apb_write(A_STAT, 8'h02, e);
    apb_read(A_STAT, d, e);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL %s w1c: got %h, want 00", tag, d); end
  endtask

  task automatic test_frame_basic();
    buf_m[0] = 8'h80; buf_m[1] = 8'h00; buf_m[2] = 8'h01;
    buf_m[3] = 8'hFF; buf_m[4] = 8'h00; buf_m[5] = 8'hAA;
    fill_buffer();
    run_and_check_frame("basic");
    checks++;
    if ({obs_d[0], obs_d[7], obs_d[8], obs_d[13], obs_d[17]} !== 5'b11010) begin
      errors++; $display("FAIL basic_edges: got %b, want 11010",
                         {obs_d[0], obs_d[7], obs_d[8], obs_d[13], obs_d[17]});
    end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 3; n++) begin
      for (int a = 0; a < NB; a++) buf_m[a] = 8'($urandom);
      fill_buffer();
      run_and_check_frame("random");
    end
  endtask

  task automatic test_busy_write();
    logic [7:0] d; logic e, e_buf, e_start;
    int bad = 0;
    for (int a = 0; a < NB; a++) buf_m[a] = 8'($urandom);
    buf_m[0][7] = 1'b1;
    fill_buffer();
    build_exp();
    apb_write(A_CTRL, 8'h01, e);
    fork
      capture(L + 20);
      begin
        repeat (40) @(posedge clk);
        apb_write(8'd0, 8'h55, e_buf);
        apb_write(A_CTRL, 8'h01, e_start);
      end
    join
    for (int i = 0; i < L + 20; i++)
      if (obs_d[i] !== ((i < L) ? exp_d[i] : 1'b0) || obs_s[i] !== (i < L)) bad++;
    checks++;
    if (e_buf !== 1'b1) begin errors++; $display("FAIL busy_wr_err: got %b, want 1", e_buf); end
    checks++;
    if (e_start !== 1'b0) begin errors++; $display("FAIL busy_start_err: got %b, want 0", e_start); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL busy_wave: got %0d bad cycles, want 0", bad); end
    apb_read(8'd0, d, e);
    checks++;
    if ({e, d} !== {1'b0, exp_rb(0)}) begin errors++; $display("FAIL busy_buf: got %h, want %h", d, exp_rb(0)); end
    apb_write(A_STAT, 8'h02, e);
  endtask

  task automatic test_loop();
    logic [7:0] d; logic e;
    int bad = 0, first = -1;
    for (int a = 0; a < NB; a++) buf_m[a] = 8'($urandom);
    fill_buffer();
    build_exp();
    apb_write(A_CTRL, 8'h03, e);
    fork
      capture(2 * L + 30);
      begin
        repeat (L + 100) @(posedge clk);
        apb_write(A_CTRL, 8'h00, e);
      end
    join
    for (int i = 0; i < 2 * L + 30; i++) begin
      logic ed = (i < 2 * L) ? exp_d[i % L] : 1'b0;
      if (obs_d[i] !== ed || obs_s[i] !== (i < 2 * L)) begin bad++; if (first < 0) first = i; end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL loop_wave: got %0d bad cycles (first %0d), want 0", bad, first); end
    apb_read(A_STAT, d, e);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL loop_done: got %h, want 02", d); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d; logic e;
    int bad = 0;
    apb_write(A_CTRL, 8'h01, e);
    capture(30);
    #3 rst = 1;
    #1;
    checks++;
    if ({neo_d, neo_s} !== 2'b00) begin errors++; $display("FAIL rst_mid_out: got %b, want 00", {neo_d, neo_s}); end
    psel = 1; penable = 1; pwrite = 0; paddr = A_STAT;
    #1;
    checks++;
    if (prdata !== 8'h00) begin errors++; $display("FAIL rst_mid_stat: got %h, want 00", prdata); end
    psel = 0; penable = 0;
    @(negedge clk) rst = 0;
    capture(TRESET + 20);
    for (int i = 0; i < TRESET + 20; i++) if (obs_d[i] !== 1'b0 || obs_s[i] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rst_mid_idle: got %0d bad cycles, want 0", bad); end
    apb_read(8'd1, d, e);
    checks++;
    if (d !== exp_rb(1)) begin errors++; $display("FAIL rst_buf_keep: got %h, want %h", d, exp_rb(1)); end
  endtask

  initial begin
    test_reset();
    test_readback();
    test_unmapped();
    test_frame_basic();
    test_random_frames();
    test_busy_write();
    test_loop();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
